// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and the stereo sample-pair type for the I2S
// frame controller and its sample FIFO.
package i2s_pkg;
  localparam int I2S_WORD_W     = 32;
  localparam int I2S_SCLK_DIV   = 8;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FIFO_DEPTH = 4;

  // Left word sits in the upper half so {s_left, s_right} maps directly.
  typedef struct packed {
    logic [I2S_WORD_W-1:0] left;
    logic [I2S_WORD_W-1:0] right;
  } stereo_t;
endpackage

// File: rtl/i2s_frame_ctrl_if.sv
// i2s_frame_ctrl_if: valid/ready sample-pair stream from the DDS core.
//   s_valid  - pair valid (master drives)
//   s_ready  - FIFO can accept (slave drives)
//   s_left   - left sample, two's complement
//   s_right  - right sample, two's complement
interface i2s_frame_ctrl_if;
  import i2s_pkg::*;
  logic                  s_valid;
  logic                  s_ready;
  logic [I2S_WORD_W-1:0] s_left;
  logic [I2S_WORD_W-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/stereo_fifo.sv
// stereo_fifo: synchronous FIFO for stereo sample pairs.
//   clk, rst_n   - clock, async active-low reset (empties the FIFO)
//   push, din    - write request/data; ignored while full
//   pop, dout    - read request; dout shows the oldest entry (show-ahead)
//   level        - entries held; full/empty derived from it
// A push while full is refused even if a pop happens on the same edge,
// since full reflects the pre-pop level.
module stereo_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push, w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset; level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/i2s_frame_ctrl.sv
// i2s_frame_ctrl: buffers stereo pairs and generates I2S framing on mclk.
//   mclk, rst_n       - master clock, async active-low reset
//   s (slave)         - valid/ready sample-pair input stream
//   sclk_o, lrclk_o   - bit clock (mclk/SCLK_DIV, 50%), word select (0=left)
//   l_en, r_en        - one-sclk-period load strobes at lrclk fall / rise
//   l_din, r_din      - current frame's words, held for the whole frame
//   underflow         - sticky: FIFO was empty at a frame start
//   fifo_level        - entries held
// Build option I2S_UNDERFLOW_HOLD_EN: on underflow repeat the previous
// words; without it the words are muted to zero.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV   = I2S_SCLK_DIV,
  parameter int SLOT_BITS  = I2S_SLOT_BITS,
  parameter int FIFO_DEPTH = I2S_FIFO_DEPTH
) (
  input  logic                        mclk,
  input  logic                        rst_n,
  i2s_frame_ctrl_if.slave             s,
  output logic                        sclk_o,
  output logic                        lrclk_o,
  output logic                        l_en,
  output logic                        r_en,
  output logic [I2S_WORD_W-1:0]       l_din,
  output logic [I2S_WORD_W-1:0]       r_din,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(SLOT_BITS - 1);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_sclk, r_lrclk, r_l_en, r_r_en, r_underflow;
  logic [I2S_WORD_W-1:0] r_l_din, r_r_din;

  logic    w_fall_tick, w_slot_end, w_frame_start, w_lr_rise;
  logic    w_full, w_empty;
  stereo_t w_push_pair, w_pop_pair;

  assign w_fall_tick   = (r_div_cnt == DIV_MAX);
  assign w_slot_end    = w_fall_tick && (r_bit_cnt == BIT_MAX);
  assign w_frame_start = w_slot_end && r_lrclk;
  assign w_lr_rise     = w_slot_end && !r_lrclk;
  assign w_push_pair   = '{left: s.s_left, right: s.s_right};

  assign s.s_ready  = !w_full;
  assign sclk_o     = r_sclk;
  assign lrclk_o    = r_lrclk;
  assign l_en       = r_l_en;
  assign r_en       = r_r_en;
  assign l_din      = r_l_din;
  assign r_din      = r_r_din;
  assign underflow  = r_underflow;

  stereo_fifo #(.DEPTH(FIFO_DEPTH), .W(2*I2S_WORD_W)) u_fifo (
    .clk   (mclk),
    .rst_n (rst_n),
    .push  (s.s_valid),
    .din   (w_push_pair),
    .pop   (w_frame_start),
    .dout  (w_pop_pair),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_sclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_l_en      <= 1'b0;
      r_r_en      <= 1'b0;
      r_underflow <= 1'b0;
      r_l_din     <= '0;
      r_r_din     <= '0;
    end else begin
      r_div_cnt <= w_fall_tick ? '0 : r_div_cnt + 1'b1;
      // Registered compare lags div_cnt by one mclk: sclk is high for
      // div_cnt 1..SCLK_DIV/2 and low across the wrap, so lrclk and the
      // strobes, which change on the wrap edge, always move with sclk low.
      r_sclk <= (r_div_cnt < DIV_HALF);
      if (w_fall_tick) begin
        r_bit_cnt <= (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + 1'b1;
        // Strobes span exactly one fall_tick interval (SCLK_DIV mclk).
        r_l_en    <= w_frame_start;
        r_r_en    <= w_lr_rise;
      end
      if (w_slot_end) r_lrclk <= ~r_lrclk;
      if (w_frame_start) begin
        if (!w_empty) begin
          r_l_din <= w_pop_pair.left;
          r_r_din <= w_pop_pair.right;
        end else begin
          r_underflow <= 1'b1;
`ifndef I2S_UNDERFLOW_HOLD_EN
          r_l_din <= '0;
          r_r_din <= '0;
`endif
        end
      end
    end
  end
endmodule
